ps2_key_controller: RTL and testbench

Sequencing and decode controller for the PS/2 receive path. It holds the receiver armed for incoming data and consumes each completed byte (`received_data` / `received_data_en`). It assembles multi-byte scan-code frames (E0 extended prefix, F0 break prefix) into make/break events for the six game keys, keeps a live held-key bitmap, and queues change events in a 4-deep FIFO for the maze game logic. A watchdog abandons partial frames when the keyboard stalls.

---
 rtl/ps2_key_controller.sv | 175 +++++++++++++++++
 tb/tb_ps2_key_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_controller.sv
// PS/2 scan-code frame decoder: turns E0/F0-prefixed byte streams into make/break events
// for six game keys, keeps a held-key bitmap and queues changes in a 4-entry FIFO.
module ps2_key_controller #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TIMEOUT_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       wait_for_incoming_data,
    output logic [5:0] key_held,
    output logic       event_valid,
    output logic [2:0] event_code,
    output logic       event_make,
    input  logic       event_ready,
    output logic       overflow,
    output logic       timeout_err
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]           BYTE_EXT  = 8'hE0;
    localparam logic [7:0]           BYTE_BRK  = 8'hF0;
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = TIMEOUT_W'(1);

    // Returns {hit, key index}; the ext flag must match exactly, so a bare 75 or an E0 5A misses.
    function automatic logic [3:0] key_lookup(input logic ext, input logic [7:0] code);
        logic [3:0] res;
        res = 4'b0000;
        case ({ext, code})
            9'h175:  res = 4'b1000;
            9'h172:  res = 4'b1001;
            9'h16B:  res = 4'b1010;
            9'h174:  res = 4'b1011;
            9'h05A:  res = 4'b1100;
            9'h076:  res = 4'b1101;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    state_t               state_r, state_nxt_s;
    logic [TIMEOUT_W-1:0] wdog_r;
    logic [5:0]           key_held_r, held_nxt_s, key_mask_s;
    logic [3:0]           fifo_r [4];
    logic [1:0]           wr_ptr_r, rd_ptr_r;
    logic [2:0]           count_r, count_nxt_s;
    logic                 overflow_r, timeout_err_r, wait_r;
    logic                 byte_s, expire_s, dec_en_s, dec_ext_s, dec_brk_s;
    logic [3:0]           lookup_s;
    logic                 held_bit_s, push_s, pop_s, full_s, push_ok_s, drop_s;

    // Frame sequencing and watchdog expiry; a byte in the expiry cycle takes priority
    always_comb begin
        state_nxt_s = state_r;
        byte_s      = enable && received_data_en;
        expire_s    = 1'b0;
        dec_en_s    = 1'b0;
        dec_ext_s   = 1'b0;
        dec_brk_s   = 1'b0;
        if (byte_s) begin
            if (received_data == BYTE_EXT) begin
                state_nxt_s = ST_EXT;
            end else if (received_data == BYTE_BRK) begin
                case (state_r)
                    ST_EXT, ST_EXT_BRK: state_nxt_s = ST_EXT_BRK;
                    default:            state_nxt_s = ST_BRK;
                endcase
            end else begin
                dec_en_s    = 1'b1;
                dec_ext_s   = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);
                dec_brk_s   = (state_r == ST_BRK) || (state_r == ST_EXT_BRK);
                state_nxt_s = ST_IDLE;
            end
        end else if (enable && (state_r != ST_IDLE) && (wdog_r == WDOG_LAST)) begin
            expire_s    = 1'b1;
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Key decode, held-bitmap update and FIFO push/pop qualification
    always_comb begin
        lookup_s    = key_lookup(dec_ext_s, received_data);
        key_mask_s  = 6'b000001 << lookup_s[2:0];
        held_bit_s  = |(key_held_r & key_mask_s);
        push_s      = dec_en_s && lookup_s[3] && (held_bit_s == dec_brk_s);
        pop_s       = (count_r != 3'd0) && event_ready;
        full_s      = (count_r == 3'd4);
        push_ok_s   = push_s && (!full_s || pop_s);
        drop_s      = push_s && full_s && !pop_s;
        count_nxt_s = count_r + {2'b00, push_ok_s} - {2'b00, pop_s};
        if (push_s) begin
            held_nxt_s = dec_brk_s ? (key_held_r & ~key_mask_s) : (key_held_r | key_mask_s);
        end else begin
            held_nxt_s = key_held_r;
        end
    end

    // Frame state, watchdog, held keys and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            wdog_r        <= {TIMEOUT_W{1'b0}};
            key_held_r    <= 6'b000000;
            overflow_r    <= 1'b0;
            timeout_err_r <= 1'b0;
        end else if (!enable) begin
            state_r       <= ST_IDLE;
            wdog_r        <= {TIMEOUT_W{1'b0}};
            key_held_r    <= 6'b000000;
            overflow_r    <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (byte_s || expire_s || (state_r == ST_IDLE)) begin
                wdog_r <= {TIMEOUT_W{1'b0}};
            end else begin
                wdog_r <= wdog_r + WDOG_ONE;
            end
            key_held_r    <= held_nxt_s;
            overflow_r    <= overflow_r | drop_s;
            timeout_err_r <= expire_s;
        end
    end

    // Receiver arm tracks enable one cycle late
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_r <= 1'b0;
        end else begin
            wait_r <= enable;
        end
    end

    // Event FIFO: entries are {make, code}, storage cleared on flush so the head reads zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
            for (int i = 0; i < 4; i++) fifo_r[i] <= 4'b0000;
        end else if (!enable) begin
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
            for (int i = 0; i < 4; i++) fifo_r[i] <= 4'b0000;
        end else begin
            if (push_ok_s) begin
                fifo_r[wr_ptr_r] <= {!dec_brk_s, lookup_s[2:0]};
                wr_ptr_r         <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            count_r <= count_nxt_s;
        end
    end

    assign wait_for_incoming_data = wait_r;
    assign key_held               = key_held_r;
    assign event_valid            = (count_r != 3'd0);
    assign event_code             = fifo_r[rd_ptr_r][2:0];
    assign event_make             = fifo_r[rd_ptr_r][3];
    assign overflow               = overflow_r;
    assign timeout_err            = timeout_err_r;
endmodule

// File: tb/tb_ps2_key_controller.sv
// Bench for ps2_key_controller: directed scenarios plus randomized frames against a
// prefix-flag / queue reference model.
module tb_ps2_key_controller;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst_n, enable, received_data_en, event_ready;
    logic [7:0] received_data;
    logic       wait_for_incoming_data, event_valid, event_make, overflow, timeout_err;
    logic [5:0] key_held;
    logic [2:0] event_code;

    int checks = 0;
    int failures = 0;

    // reference model: prefix flags, held keys, expected event queue
    bit         m_held [6];
    logic [3:0] m_q [$];
    bit         m_ext, m_brk, m_ovf, m_tout;
    int         m_gap;
    logic [7:0] tbl_byte [6] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h76};
    bit         tbl_ext  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    ps2_key_controller #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
        .clk(clk), .reset(rst_n), .enable(enable),
        .received_data(received_data), .received_data_en(received_data_en),
        .wait_for_incoming_data(wait_for_incoming_data), .key_held(key_held),
        .event_valid(event_valid), .event_code(event_code), .event_make(event_make),
        .event_ready(event_ready), .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic int lookup(bit ext, logic [7:0] b);
        for (int i = 0; i < 6; i++) if (tbl_byte[i] == b && tbl_ext[i] == ext) return i;
        return -1;
    endfunction

    function automatic logic [5:0] held_vec();
        logic [5:0] v;
        for (int i = 0; i < 6; i++) v[i] = m_held[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 6; i++) m_held[i] = 1'b0;
        m_q.delete();
        m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0; m_tout = 1'b0; m_gap = 0;
    endtask

    task automatic model_edge(bit bv, logic [7:0] b, bit rdy);
        int code;
        bit push;
        logic [3:0] entry;
        push = 1'b0;
        entry = 4'h0;
        if (!enable) begin
            model_clear();
            return;
        end
        m_tout = 1'b0;
        if (bv) begin
            m_gap = 0;
            if (b == 8'hE0) begin
                m_ext = 1'b1; m_brk = 1'b0;
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
                code = lookup(m_ext, b);
                if (code >= 0 && m_held[code] == m_brk) begin
                    m_held[code] = !m_brk;
                    push = 1'b1;
                    entry = {!m_brk, 3'(code)};
                end
                m_ext = 1'b0; m_brk = 1'b0;
            end
        end else if (m_ext || m_brk) begin
            m_gap++;
            if (m_gap == TO) begin
                m_ext = 1'b0; m_brk = 1'b0; m_gap = 0; m_tout = 1'b1;
            end
        end
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < 4) m_q.push_back(entry);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(bit bv, logic [7:0] b, bit rdy);
        received_data_en = bv;
        received_data = b;
        event_ready = rdy;
        model_edge(bv, b, rdy);
        @(posedge clk);
        #1;
        received_data_en = 1'b0;
        event_ready = 1'b0;
    endtask

    task automatic send(logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; received_data_en = 1'b0; received_data = 8'h00; event_ready = 1'b0;
        model_clear();
        #12;
        checks++;
        if ({wait_for_incoming_data, key_held, event_valid, event_code, event_make, overflow, timeout_err} !== 14'b0) begin
            failures++; $display("FAIL reset_outputs: got %b expected all zero",
                {wait_for_incoming_data, key_held, event_valid, event_code, event_make, overflow, timeout_err});
        end
        @(negedge clk) rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (wait_for_incoming_data !== 1'b0) begin failures++; $display("FAIL wait_disabled: got %b expected 0", wait_for_incoming_data); end
        enable = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (wait_for_incoming_data !== 1'b1) begin failures++; $display("FAIL wait_enabled: got %b expected 1", wait_for_incoming_data); end
    endtask

    task automatic test_decode();
        send(8'h75); send(8'hF0); send(8'h75);
        checks++;
        if ({key_held, event_valid} !== 7'b0) begin failures++; $display("FAIL bare_75: got held=%b valid=%b expected 0/0", key_held, event_valid); end
        send(8'hE0); send(8'h75);
        checks++;
        if ({key_held, event_valid, event_make, event_code} !== 11'b000001_1_1_000) begin
            failures++; $display("FAIL up_make: got held=%b valid=%b ev=%b%03b expected 000001 1 1000", key_held, event_valid, event_make, event_code);
        end
        step(1'b0, 8'h00, 1'b1);
        send(8'hE0); send(8'hF0);
        checks++;
        if ({key_held, event_valid} !== 7'b000001_0) begin failures++; $display("FAIL ext_brk_partial: got held=%b valid=%b expected 000001 0", key_held, event_valid); end
        send(8'h75);
        checks++;
        if ({key_held, event_valid, event_make, event_code} !== 11'b000000_1_0_000) begin
            failures++; $display("FAIL up_break: got held=%b valid=%b ev=%b%03b expected 000000 1 0000", key_held, event_valid, event_make, event_code);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (event_valid !== 1'b0) begin failures++; $display("FAIL up_drain: got valid=%b expected 0", event_valid); end
    endtask

    task automatic test_typematic();
        send(8'h5A); send(8'h5A); send(8'h5A);
        checks++;
        if (key_held !== 6'b010000) begin failures++; $display("FAIL enter_held: got %b expected 010000", key_held); end
        send(8'hF0); send(8'h5A);
        checks++;
        if (key_held !== 6'b000000) begin failures++; $display("FAIL enter_released: got %b expected 000000", key_held); end
        checks++;
        if ({event_valid, event_make, event_code} !== 5'b1_1_100) begin failures++; $display("FAIL enter_ev1: got %b%b%03b expected 11100", event_valid, event_make, event_code); end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if ({event_valid, event_make, event_code} !== 5'b1_0_100) begin failures++; $display("FAIL enter_ev2: got %b%b%03b expected 10100", event_valid, event_make, event_code); end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (event_valid !== 1'b0) begin failures++; $display("FAIL enter_count: got valid=%b expected 0", event_valid); end
    endtask

    task automatic test_overflow_flush();
        logic [3:0] exp [4] = '{4'b1000, 4'b0000, 4'b1001, 4'b0001};
        logic [7:0] keys [3] = '{8'h75, 8'h72, 8'h6B};
        for (int k = 0; k < 3; k++) begin
            send(8'hE0); send(keys[k]); send(8'hE0); send(8'hF0); send(keys[k]);
        end
        checks++;
        if ({overflow, key_held} !== 7'b1_000000) begin failures++; $display("FAIL overflow_set: got ovf=%b held=%b expected 1 000000", overflow, key_held); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({event_valid, event_make, event_code} !== {1'b1, exp[i]}) begin
                failures++; $display("FAIL overflow_pop%0d: got %b%b%03b expected 1%b", i, event_valid, event_make, event_code, exp[i]);
            end
            step(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if ({event_valid, overflow} !== 2'b01) begin failures++; $display("FAIL overflow_drained: got valid=%b ovf=%b expected 0 1", event_valid, overflow); end
        enable = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if ({overflow, wait_for_incoming_data, key_held} !== 8'b0) begin failures++; $display("FAIL flush: got ovf=%b wait=%b held=%b expected zeros", overflow, wait_for_incoming_data, key_held); end
        enable = 1'b1;
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_timeout();
        int pulses = 0;
        send(8'hE0);
        for (int i = 0; i < TO + 2; i++) begin
            step(1'b0, 8'h00, 1'b0);
            pulses += int'(timeout_err);
            checks++;
            if (timeout_err !== ((i == TO - 1) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL timeout_cycle%0d: got %b expected %b", i, timeout_err, (i == TO - 1)); end
        end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL timeout_pulses: got %0d expected 1", pulses); end
        send(8'h74);
        checks++;
        if ({event_valid, key_held} !== 7'b0) begin failures++; $display("FAIL post_timeout_74: got valid=%b held=%b expected 0", event_valid, key_held); end
        send(8'hE0); send(8'h74);
        checks++;
        if ({event_valid, event_make, event_code} !== 5'b1_1_011) begin failures++; $display("FAIL right_make: got %b%b%03b expected 11011", event_valid, event_make, event_code); end
        step(1'b0, 8'h00, 1'b1);
        send(8'hE0);
        for (int i = 0; i < TO - 1; i++) step(1'b0, 8'h00, 1'b0);
        send(8'h6B);
        checks++;
        if ({timeout_err, event_valid, event_make, event_code, key_held} !== 12'b0_1_1_010_001100) begin
            failures++; $display("FAIL byte_wins: got tout=%b ev=%b%b%03b held=%b expected 0 11010 001100", timeout_err, event_valid, event_make, event_code, key_held);
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_full_push_pop();
        logic [3:0] exp [4] = '{4'b0100, 4'b1101, 4'b0101, 4'b1001};
        send(8'h5A); send(8'hF0); send(8'h5A); send(8'h76); send(8'hF0); send(8'h76);
        send(8'hE0);
        checks++;
        if ({event_valid, event_make, event_code} !== 5'b1_1_100) begin failures++; $display("FAIL full_head: got %b%b%03b expected 11100", event_valid, event_make, event_code); end
        step(1'b1, 8'h72, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL full_pushpop_ovf: got %b expected 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({event_valid, event_make, event_code} !== {1'b1, exp[i]}) begin
                failures++; $display("FAIL full_order%0d: got %b%b%03b expected 1%b", i, event_valid, event_make, event_code, exp[i]);
            end
            step(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if ({event_valid, key_held} !== 7'b0_001110) begin failures++; $display("FAIL full_drained: got valid=%b held=%b expected 0 001110", event_valid, key_held); end
    endtask

    task automatic test_async_reset();
        send(8'hE0); send(8'hF0);
        #3 rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({wait_for_incoming_data, key_held, event_valid, event_code, event_make, overflow, timeout_err} !== 14'b0) begin
            failures++; $display("FAIL async_reset: got %b expected all zero",
                {wait_for_incoming_data, key_held, event_valid, event_code, event_make, overflow, timeout_err});
        end
        @(negedge clk) rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        send(8'h72);
        checks++;
        if ({event_valid, key_held} !== 7'b0) begin failures++; $display("FAIL reset_72_alone: got valid=%b held=%b expected 0", event_valid, key_held); end
        send(8'hE0); send(8'h72);
        checks++;
        if ({event_valid, event_make, event_code, key_held} !== 11'b1_1_001_000010) begin
            failures++; $display("FAIL reset_down_make: got %b%b%03b held=%b expected 11001 000010", event_valid, event_make, event_code, key_held);
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            logic [8:0] acts [$];
            int k;
            bit brk;
            k = $urandom_range(0, 7);
            brk = 1'($urandom_range(0, 1));
            if (k > 5) begin
                repeat ($urandom_range(0, 2)) acts.push_back(9'h000);
                acts.push_back({1'b1, 8'($urandom_range(0, 255))});
            end else begin
                if (tbl_ext[k]) begin
                    repeat ($urandom_range(0, 2)) acts.push_back(9'h000);
                    acts.push_back(9'h1E0);
                end
                if (brk) begin
                    repeat ($urandom_range(0, 2)) acts.push_back(9'h000);
                    acts.push_back(9'h1F0);
                end
                repeat ($urandom_range(0, 2)) acts.push_back(9'h000);
                acts.push_back({1'b1, tbl_byte[k]});
            end
            foreach (acts[j]) begin
                step(acts[j][8], acts[j][7:0], 1'($urandom_range(0, 1)));
                checks++;
                if ({key_held, event_valid, overflow, timeout_err} !== {held_vec(), m_q.size() != 0, m_ovf, m_tout}) begin
                    failures++; $display("FAIL rand_state: got held=%b v=%b ovf=%b tout=%b expected held=%b v=%b ovf=%b tout=%b",
                        key_held, event_valid, overflow, timeout_err, held_vec(), m_q.size() != 0, m_ovf, m_tout);
                end
                if (m_q.size() > 0) begin
                    checks++;
                    if ({event_make, event_code} !== m_q[0]) begin
                        failures++; $display("FAIL rand_head: got %b%03b expected %b", event_make, event_code, m_q[0]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_typematic();
        test_overflow_flush();
        test_timeout();
        test_full_push_pop();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
